// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// framing bytes, message codes and the fixed ASCII message table.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [7:0] MSG_TERM = 8'h23;
  localparam logic [7:0] MSG_NL   = 8'h0A;
  localparam int         MSG_MAX  = 11;

  // Same code values as the receive path.
  localparam logic [3:0] CODE_NONE = 4'h0;
  localparam logic [3:0] CODE_EU   = 4'h1;
  localparam logic [3:0] CODE_B1   = 4'h2;
  localparam logic [3:0] CODE_B3   = 4'h3;
  localparam logic [3:0] CODE_RU   = 4'h4;
  localparam logic [3:0] CODE_CU   = 4'h5;
  localparam logic [3:0] CODE_B2   = 4'h6;
  localparam logic [3:0] CODE_B4   = 4'h7;

  // Strings are left-justified; short ones are padded with the terminator.
  function automatic logic [8*MSG_MAX-1:0] msg_str(input logic [3:0] c);
    logic [8*MSG_MAX-1:0] s;
    case (c)
      CODE_EU: s = {"FIM-EU-#", "###"};
      CODE_B1: s = "PBM-SU-B1-#";
      CODE_B3: s = "PBM-SU-B3-#";
      CODE_RU: s = {"FIM-RU-#", "###"};
      CODE_CU: s = {"FIM-CU-#", "###"};
      CODE_B2: s = "PBM-SU-B2-#";
      CODE_B4: s = "PBM-SU-B4-#";
      default: s = {MSG_MAX{MSG_TERM}};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// Combinational message ROM: (code, byte index) -> ASCII byte.
// Unknown codes and indices past the table yield the terminator.
module uart_msg_rom
  import uart_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic [7:0] idx_i,
  output logic [7:0] byte_o
);

  logic [8*MSG_MAX-1:0] str;

  always_comb begin
    str    = msg_str(code_i);
    byte_o = MSG_TERM;
    for (int i = 0; i < MSG_MAX; i++) begin
      if (idx_i == 8'(i)) byte_o = str[8*(MSG_MAX-1-i) +: 8];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one byte-level UART transmitter from N_REQ
// req/ack reporters. Define UART_TX_SCHED_NEWLINE_EN to append 0x0A after '#'.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MSG_LEN    = 11,
  parameter int TX_TIMEOUT = 10000
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] code,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               tx_err
);

  localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_q, rr_d;
  logic [3:0]       code_q, code_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             nl_q, nl_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [7:0]  rom_byte;
  logic [7:0]  req_ext;
  logic [31:0] code_ext;
  logic [7:0]  ack_ext;
  logic        found;
  int          j;

  uart_msg_rom u_rom (
    .code_i (code_q),
    .idx_i  (idx_q),
    .byte_o (rom_byte)
  );

  // Widened copies let a 3-bit requester index select without width games.
  assign req_ext  = 8'(req);
  assign code_ext = 32'(code);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    code_d  = code_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    nl_d    = nl_q;
    found   = 1'b0;
    j       = 0;
    ack_ext = '0;

    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < N_REQ; k++) begin
          j = int'(rr_q) + k;
          if (j >= N_REQ) j = j - N_REQ;
          if (!found && req_ext[j[2:0]]) begin
            found   = 1'b1;
            grant_d = j[2:0];
          end
        end
        if (found) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        code_d  = code_ext[{grant_q, 2'b00} +: 4];
        idx_d   = '0;
        nl_d    = 1'b0;
        state_d = (code_d == CODE_NONE) ? ST_ACK : ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = nl_q ? MSG_NL : rom_byte;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done is checked first so it wins over a coincident timeout.
        if (tx_done) begin
          if (nl_q) begin
            state_d = ST_ACK;
          end else if (data_q == MSG_TERM) begin
`ifdef UART_TX_SCHED_NEWLINE_EN
            nl_d    = 1'b1;
            state_d = ST_LOAD;
`else
            state_d = ST_ACK;
`endif
          end else if (idx_q == 8'(MSG_LEN - 1)) begin
            state_d = ST_ACK;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_LOAD;
          end
        end else if (cnt_q == CNT_W'(TX_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (!req_ext[grant_q]) begin
          rr_d    = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ack is a registered copy of "next state is ACK" for the granted port.
    if (state_d == ST_ACK) ack_ext[grant_d] = 1'b1;
    ack_d = ack_ext[N_REQ-1:0];
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      code_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      nl_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      nl_q    <= nl_d;
      ack_q   <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = data_q;
  assign tx_start = (state_q == ST_SEND);
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected bytes are queued by the
// stimulus, a monitor checks every tx_start, a responder models uart_tx.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_NEWLINE_EN
  localparam int NLN = 1;
`else
  localparam int NLN = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic [2:0]  grant_id;
  logic        tx_err;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         npulse = 0;
  int         last_done_cyc = -100;
  bit         withhold = 0;
  logic [7:0] exp_q[$];

  uart_tx_sched #(.N_REQ(4), .MSG_LEN(11), .TX_TIMEOUT(50)) dut (
    .clk_50M  (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id),
    .tx_err   (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end else begin
      $display("ok   %s: %0d at cycle %0d", name, act, cyc);
    end
  endtask

  task automatic push_raw(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_msg(input string s);
    push_raw(s);
    if (NLN != 0) exp_q.push_back(8'h0A);
  endtask

  task automatic wait_ack(input int i, output int at);
    at = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ack[i]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL ack%0d_wait: got no ack within 3000 cycles, want ack high", i);
    end
  endtask

  // Monitor: every launched byte must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      npulse++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL byte_unexpected: got 0x%0h with empty queue, want no tx_start", tx_data);
      end else begin
        chk("byte", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Transmitter model: tx_done five cycles after each tx_start.
  initial begin
    int done_cnt;
    done_cnt = 0;
    tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) begin
            tx_done       = 1'b1;
            last_done_cyc = cyc;
          end
        end
        if (tx_start && !withhold) done_cnt = 5;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int np;
    int s;
    rst_n = 1'b0;
    req   = '0;
    code  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_tx_err", int'(tx_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, code 2, full 11-byte message.
    np = npulse;
    code[7:4] = 4'd2;
    req[1] = 1'b1;
    push_msg("PBM-SU-B1-#");
    repeat (3) @(negedge clk);
    chk("first_start", int'(tx_start), 1);
    chk("first_grant", int'(grant_id), 1);
    chk("first_busy", int'(busy), 1);
    wait_ack(1, at);
    chk("ack_latency", at, last_done_cyc + 1);
    chk("pulses_b1", npulse - np, 11 + NLN);
    req[1] = 1'b0;
    @(negedge clk);
    chk("ack1_fall", int'(ack[1]), 0);
    chk("idle_busy", int'(busy), 0);

    // Two simultaneous requesters after reset: 0 then 2.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    code[3:0] = 4'd1;
    code[11:8] = 4'd5;
    push_msg("FIM-EU-#");
    push_msg("FIM-CU-#");
    np = npulse;
    req = 4'b0101;
    wait_ack(0, at);
    chk("rr_first_grant", int'(grant_id), 0);
    chk("pulses_eu", npulse - np, 8 + NLN);
    req[0] = 1'b0;
    wait_ack(2, at);
    chk("rr_second_grant", int'(grant_id), 2);
    req[2] = 1'b0;
    @(negedge clk);
    chk("ack2_fall", int'(ack[2]), 0);

    // rr now 3: requester 3 (code 0) beats requester 0.
    code[15:12] = 4'd0;
    code[3:0] = 4'd4;
    push_msg("FIM-RU-#");
    np = npulse;
    req = 4'b1001;
    @(negedge clk);
    chk("code0_ack_early", int'(ack[3]), 0);
    @(negedge clk);
    chk("code0_ack", int'(ack[3]), 1);
    chk("code0_grant", int'(grant_id), 3);
    req[3] = 1'b0;
    @(negedge clk);
    chk("code0_pulses", npulse - np, 0);
    chk("code0_ack_fall", int'(ack[3]), 0);
    wait_ack(0, at);
    chk("pulses_ru", npulse - np, 8 + NLN);
    req[0] = 1'b0;
    @(negedge clk);

    // Timeout: tx_done withheld.
    withhold = 1'b1;
    code[7:4] = 4'd2;
    push_raw("P");
    req[1] = 1'b1;
    s = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tx_start) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      total++;
      bad++;
      $display("FAIL to_start: got no tx_start within 50 cycles, want tx_start");
    end
    repeat (50) @(negedge clk);
    chk("to_err_before", int'(tx_err), 0);
    chk("to_busy_before", int'(busy), 1);
    @(negedge clk);
    chk("to_err_set", int'(tx_err), 1);
    chk("to_ack", int'(ack[1]), 1);
    withhold = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    chk("to_ack_fall", int'(ack[1]), 0);
    code[11:8] = 4'd1;
    push_msg("FIM-EU-#");
    req[2] = 1'b1;
    wait_ack(2, at);
    chk("to_next_grant", int'(grant_id), 2);
    chk("to_err_sticky", int'(tx_err), 1);
    req[2] = 1'b0;
    @(negedge clk);

    // Asynchronous reset at byte 4, then restart from byte 0.
    code[3:0] = 4'd2;
    push_raw("PBM-S");
    np = npulse;
    req[0] = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (npulse - np >= 5) break;
    end
    chk("mid_pulses", npulse - np, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", int'(ack), 0);
    chk("arst_tx_data", int'(tx_data), 0);
    chk("arst_tx_start", int'(tx_start), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_grant_id", int'(grant_id), 0);
    chk("arst_tx_err", int'(tx_err), 0);
    @(negedge clk);
    push_msg("PBM-SU-B1-#");
    np = npulse;
    rst_n = 1'b1;
    wait_ack(0, at);
    chk("restart_pulses", npulse - np, 11 + NLN);
    req[0] = 1'b0;
    @(negedge clk);
    chk("restart_ack_fall", int'(ack[0]), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
